// File: rtl/mult_div.sv
// Iterative multiply/divide unit beside the EX stage.
// Runs a 32-step shift-add multiply or restoring divide and holds the
// {HI, LO} result with done high until EX retires the instruction.
// Optional build macro: MULT_DIV_FAST_MULT_EN (single-cycle multiply).
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_downstream,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        done,
    output logic        busy,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] hold;      // multiplicand or divisor magnitude
    logic        neg_q;     // negate product / quotient
    logic        neg_r;     // negate remainder

    logic        is_mult, is_div, is_signed;
    logic        op1_neg, op2_neg;
    logic [31:0] abs_1, abs_2;

    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_fix;
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [31:0] quo, rem;
    logic [63:0] div_fix;

    // Op decode and operand magnitudes for the start cycle
    always_comb begin
        is_mult   = (funct == 6'h18) || (funct == 6'h19);
        is_div    = (funct == 6'h1A) || (funct == 6'h1B);
        is_signed = (funct == 6'h18) || (funct == 6'h1A);
        op1_neg   = is_signed & operand_1[31];
        op2_neg   = is_signed & operand_2[31];
        abs_1     = op1_neg ? (32'd0 - operand_1) : operand_1;
        abs_2     = op2_neg ? (32'd0 - operand_2) : operand_2;
    end

    // One shift-add multiply step and one restoring divide step, plus final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? hold : 32'd0)};
        mul_next  = {mul_sum, acc[31:1]};
        mul_fix   = neg_q ? (64'd0 - mul_next) : mul_next;

        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, hold};
        div_ge    = (div_shift >= {1'b0, hold});
        div_next  = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                           : {div_shift[31:0], acc[30:0], 1'b0};
        rem       = div_next[63:32];
        quo       = div_next[31:0];
        div_fix   = {(neg_r ? (32'd0 - rem) : rem), (neg_q ? (32'd0 - quo) : quo)};
    end

`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] fast_a, fast_b, fast_prod;

    // Full-width product in the start cycle; sign extension makes the low 64 bits signed-correct
    always_comb begin
        fast_a    = {{32{op1_neg}}, operand_1};
        fast_b    = {{32{op2_neg}}, operand_2};
        fast_prod = fast_a * fast_b;
    end
`endif

    // Control FSM with iteration datapath; result written only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            hold   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mult) begin
`ifdef MULT_DIV_FAST_MULT_EN
                        result <= fast_prod;
                        state  <= DONE;
`else
                        acc    <= {32'd0, abs_2};
                        hold   <= abs_1;
                        neg_q  <= op1_neg ^ op2_neg;
                        cnt    <= '0;
                        state  <= MUL;
`endif
                    end else if (is_div) begin
                        if (operand_2 == 32'd0) begin
                            result <= {operand_1, 32'hFFFF_FFFF};
                            state  <= DONE;
                        end else begin
                            acc    <= {32'd0, abs_1};
                            hold   <= abs_2;
                            neg_q  <= op1_neg ^ op2_neg;
                            neg_r  <= op1_neg;
                            cnt    <= '0;
                            state  <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= mul_fix;
                        state  <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= div_fix;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_downstream) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done = (state == DONE);
    assign busy = (state == MUL) || (state == DIV);

endmodule
